// File: rtl/traffic_timing_pkg.sv
// Shared constants and sizing helper for the traffic-light timing generator.
package traffic_timing_pkg;

  localparam int CLK_DIV     = 10;
  localparam int LONG_TICKS  = 25;
  localparam int SHORT_TICKS = 5;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tt_countdown_timer.sv
// One countdown timer: request edge detect, tick-driven counter, sticky done flag.
module tt_countdown_timer
  import traffic_timing_pkg::*;
#(
  parameter int TICKS = SHORT_TICKS
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic req,
  input  logic tick,
  output logic done
);

  localparam int            CW   = cnt_width(TICKS);
  localparam logic [CW-1:0] LOAD = CW'(TICKS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          req_q;
  logic          req_hist;
  logic          running;
  logic [CW-1:0] cnt;
  logic          start;

  // Start is a rising edge of the registered request; a start overrides a coincident tick.
  assign start = req_q & ~req_hist;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      req_q    <= 1'b0;
      req_hist <= 1'b0;
      running  <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      req_q    <= req;
      req_hist <= req_q;
      if (start) begin
        cnt     <= LOAD;
        running <= 1'b1;
        done    <= 1'b0;
      end else if (tick && running) begin
        if (cnt == ONE) begin
          cnt     <= '0;
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

endmodule

// File: rtl/traffic_timing_circuit.sv
// Timing generator: free-running clock divider plus long and short countdown timers.
module traffic_timing_circuit
  import traffic_timing_pkg::*;
#(
  parameter int P_CLK_DIV     = CLK_DIV,
  parameter int P_LONG_TICKS  = LONG_TICKS,
  parameter int P_SHORT_TICKS = SHORT_TICKS
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_Long_time,
  input  logic i_Short_time,
  output logic o_long_timer,
  output logic o_short_timer,
  output logic o_clk
);

  localparam int            DW       = cnt_width(P_CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(P_CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(P_CLK_DIV / 2);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          tick;

  assign tick    = (div_cnt == DIV_LAST);
  assign div_nxt = tick ? '0 : div_cnt + DW'(1);

  // o_clk is decoded from the next count so it lines up with div_cnt after the edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      div_cnt <= '0;
      o_clk   <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      o_clk   <= (div_nxt >= DIV_HALF);
    end
  end

  tt_countdown_timer #(.TICKS(P_LONG_TICKS)) u_long (
    .gclk   (i_clk),
    .grst_n (i_reset),
    .req    (i_Long_time),
    .tick   (tick),
    .done   (o_long_timer)
  );

  tt_countdown_timer #(.TICKS(P_SHORT_TICKS)) u_short (
    .gclk   (i_clk),
    .grst_n (i_reset),
    .req    (i_Short_time),
    .tick   (tick),
    .done   (o_short_timer)
  );

endmodule

// File: tb/tb_traffic_timing_circuit.sv
// Bench for traffic_timing_circuit: absolute-edge expiry model plus directed scenarios.
module tb_traffic_timing_circuit;

  localparam int DIV = 10;
  localparam int LT  = 25;
  localparam int ST  = 5;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  logic i_Long_time = 1'b0;
  logic i_Short_time = 1'b0;
  logic o_long_timer, o_short_timer, o_clk;

  int tot = 0;
  int pass = 0;

  traffic_timing_circuit dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_Long_time   (i_Long_time),
    .i_Short_time  (i_Short_time),
    .o_long_timer  (o_long_timer),
    .o_short_timer (o_short_timer),
    .o_clk         (o_clk)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    tot++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: k counts edges since reset release; ticks fall on edges k%DIV==0.
  // A start detected at edge L expires at the TICKS-th tick strictly after L.
  int k = 0;
  bit lp1, lp2, sp1, sp2;
  bit lval, sval;
  int lexp, sexp, lload, sload;
  bit prev_l, prev_s;
  int lrise = 0, srise = 0;

  function automatic int expiry(input int load_edge, input int ticks);
    return ((load_edge / DIV) + 1) * DIV + DIV * (ticks - 1);
  endfunction

  always @(posedge i_clk) begin
    int el, es, ec;
    if (!i_reset) begin
      k = 0; lp1 = 0; lp2 = 0; sp1 = 0; sp2 = 0; lval = 0; sval = 0;
    end else begin
      k++;
      if (lp1 && !lp2) begin lval = 1; lload = k; lexp = expiry(k, LT); end
      if (sp1 && !sp2) begin sval = 1; sload = k; sexp = expiry(k, ST); end
      lp2 = lp1; lp1 = i_Long_time;
      sp2 = sp1; sp1 = i_Short_time;
    end
    #1;
    ec = i_reset ? int'((k % DIV) >= DIV / 2) : 0;
    el = (i_reset && lval && k >= lexp) ? 1 : 0;
    es = (i_reset && sval && k >= sexp) ? 1 : 0;
    chk("o_clk", int'(o_clk), ec);
    chk("o_long_timer", int'(o_long_timer), el);
    chk("o_short_timer", int'(o_short_timer), es);
    if (i_reset && o_long_timer && !prev_l) begin
      lrise++;
      chk("long_window", int'((k - lload) >= (LT-1)*DIV+1 && (k - lload) <= LT*DIV), 1);
    end
    if (i_reset && o_short_timer && !prev_s) begin
      srise++;
      chk("short_window", int'((k - sload) >= (ST-1)*DIV+1 && (k - sload) <= ST*DIV), 1);
    end
    prev_l = i_reset && o_long_timer;
    prev_s = i_reset && o_short_timer;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    cyc(2);
    chk("rst_long", int'(o_long_timer), 0);
    chk("rst_short", int'(o_short_timer), 0);
    chk("rst_clk", int'(o_clk), 0);
    i_reset = 1'b1;
    cyc(4); chk("clk_e4", int'(o_clk), 0);
    cyc(1); chk("clk_e5", int'(o_clk), 1);
    cyc(5); chk("clk_e10", int'(o_clk), 0);
    cyc(5); chk("clk_e15", int'(o_clk), 1);

    // Long held for 3 cycles: one start only.
    i_Long_time = 1'b1; cyc(3); i_Long_time = 1'b0;
    cyc(270);
    chk("long_expired", int'(o_long_timer), 1);
    chk("short_idle", int'(o_short_timer), 0);

    // Short pulse, then retrigger while done.
    i_Short_time = 1'b1; cyc(1); i_Short_time = 1'b0;
    cyc(60);
    chk("short_expired", int'(o_short_timer), 1);
    i_Short_time = 1'b1; cyc(1); i_Short_time = 1'b0;
    cyc(3);
    chk("short_cleared", int'(o_short_timer), 0);
    cyc(60);

    // Long restarted mid-count.
    i_Long_time = 1'b1; cyc(1); i_Long_time = 1'b0;
    cyc(100);
    i_Long_time = 1'b1; cyc(1); i_Long_time = 1'b0;
    cyc(200);
    chk("long_no_early", int'(o_long_timer), 0);
    cyc(70);

    // Both at once, held high.
    i_Long_time = 1'b1; i_Short_time = 1'b1;
    cyc(300);
    i_Long_time = 1'b0; i_Short_time = 1'b0;
    cyc(2);
    chk("both_long", int'(o_long_timer), 1);
    chk("both_short", int'(o_short_timer), 1);

    // Async reset mid-count.
    i_Long_time = 1'b1; cyc(1); i_Long_time = 1'b0;
    cyc(50);
    @(posedge i_clk); #3;
    i_reset = 1'b0;
    #1;
    chk("async_long", int'(o_long_timer), 0);
    chk("async_short", int'(o_short_timer), 0);
    chk("async_clk", int'(o_clk), 0);
    cyc(2);
    i_reset = 1'b1;
    cyc(300);
    chk("post_rst_long", int'(o_long_timer), 0);
    chk("long_rises", lrise, 3);
    chk("short_rises", srise, 3);

    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule

// File: doc/traffic_timing_circuit.md
# traffic_timing_circuit

Timing generator for the traffic-light controller. Divides the system clock into a slow 50%-duty timing clock and runs two independent countdown timers, long and short, on that time base. The controller FSM triggers the timers and reads their expiry flags to sequence the light phases. The block is fully synchronous to one clock; the divided clock is an output only and never clocks internal logic.

## Interface
- CLK_DIV, 10: system-clock cycles per o_clk period; even, ≥2.
- LONG_TICKS, 25: o_clk periods counted by the long timer; ≥1.
- SHORT_TICKS, 5: o_clk periods counted by the short timer; ≥1.
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_Long_time  input  1  long-timer start request, sampled on i_clk.
- i_Short_time  input  1  short-timer start request, sampled on i_clk.
- o_long_timer  output  1  long-timer expired flag.
- o_short_timer  output  1  short-timer expired flag.
- o_clk  output  1  divided timing clock, registered.

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
  - o_clk is 0 while div_cnt < CLK_DIV/2 and 1 otherwise. It is registered, so it is glitch-free.
  - Internal tick is a one-cycle pulse in the cycle where div_cnt == CLK_DIV-1.
- Trigger detect: each request input is registered once. A start is a sampled 0→1 transition, so holding a request high starts the timer only once. Pulses that do not span a rising i_clk edge are not seen.
- Each timer holds cnt (width clog2(TICKS+1)), a running bit, and a done bit.
- On start: cnt ← TICKS, running ← 1, done ← 0.
- On tick while running:
  - If cnt == 1: cnt ← 0, running ← 0, done ← 1.
  - Otherwise: cnt ← cnt-1.
- done stays high until the next start of that timer or reset.
- o_long_timer = long done and o_short_timer = short done, both direct register outputs.
- Boundary cases:
  - A start while running restarts from TICKS. done stays 0.
  - A start and a tick in the same cycle: start wins, the tick is not consumed.
  - A start while done is high clears done on the next edge.
  - Both starts in the same cycle: both timers start independently.
  - The divider free-runs and is never resynchronised by starts.
- Reset (async assert, sync release):
  - div_cnt=0, o_clk=0, trigger history=0, cnt=0, running=0.
  - o_long_timer=0 and o_short_timer=0.
  - Reset mid-count aborts the count with no expiry.

## Timing
- Start latency: the request is sampled at edge N and detected at edge N+1, and cnt is loaded at that edge.
- Expiry: done rises on the edge that consumes the TICKS-th tick after load. The load-to-done delay is between (TICKS-1)·CLK_DIV+1 and TICKS·CLK_DIV cycles.
- With defaults:
  - Long timer expires 241–250 cycles after load.
  - Short timer expires 41–50 cycles after load.
- o_clk period is CLK_DIV cycles. The first rising o_clk edge comes CLK_DIV/2 cycles after reset release.

## Structure
- Shared package traffic_timing_pkg holds:
  - Default constants: CLK_DIV, LONG_TICKS, SHORT_TICKS.
  - A width-helper function for counter sizing.
- Sub-module tt_countdown_timer (parameter TICKS) contains the edge detect, counter, and done flag. It is instantiated twice.
- The divider stays inline in the top module.

## Test plan
- Hold i_reset=0 for 2 cycles → all outputs 0. Release → o_clk rises 5 cycles later and has a 10-cycle period, 5 high / 5 low.
- Pulse i_Long_time for 3 cycles → o_long_timer rises 241–250 cycles after load, stays high, and o_short_timer stays 0.
- Pulse i_Short_time for 1 cycle → o_short_timer rises 41–50 cycles after load. A new pulse drops it to 0 one cycle after detection and it re-expires.
- Restart i_Long_time at ~100 cycles into a count → expiry moves to 241–250 cycles after the second load, with no early assertion.
- Start both timers in the same cycle → short expires first and long later, each in its window. Holding the inputs high does not reload either timer.
- Assert i_reset=0 mid-count, asynchronously between edges → outputs and o_clk go 0 immediately. After release, no expiry occurs without a new start.
